multicycle_ctrl: RTL



---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath.
interface multicycle_ctrl_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] opCode;
  logic            zero;
  logic            memReady;
  logic            memRead;
  logic            memWrite;
  logic            iOrD;
  logic            irWrite;
  logic            pcEn;
  logic [1:0]      pcSrc;
  logic            aluSrcA;
  logic [1:0]      aluSrcB;
  logic [1:0]      aluOp;
  logic            regWrite;
  logic            regDst;
  logic            memToReg;
  logic            illegal;

  modport master (
    input  opCode, zero, memReady,
    output memRead, memWrite, iOrD, irWrite, pcEn, pcSrc, aluSrcA, aluSrcB,
           aluOp, regWrite, regDst, memToReg, illegal
  );

  modport slave (
    output opCode, zero, memReady,
    input  memRead, memWrite, iOrD, irWrite, pcEn, pcSrc, aluSrcA, aluSrcB,
           aluOp, regWrite, regDst, memToReg, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: fetch, decode, execute,
// memory and writeback, with memory-ready stalls and a sticky illegal-opcode trap.
module multicycle_ctrl #(
  parameter int OP_W = 6
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;

  // Asynchronous reset drops the state to RST, which zeroes every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RST;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    case (state_reg)
      S_RST: state_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.memReady;
        pc_en     = bus.memReady;
        if (bus.memReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (bus.opCode == OP_LW || bus.opCode == OP_SW) state_next = S_MEMADR;
        else if (bus.opCode == OP_RTYPE)                state_next = S_EXEC;
        else if (bus.opCode == OP_BEQ)                  state_next = S_BRANCH;
        else if (bus.opCode == OP_ADDI)                 state_next = S_ADDIEX;
        else if (bus.opCode == OP_J)                    state_next = S_JUMP;
        else                                            state_next = S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (bus.opCode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.memReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.memReady) state_next = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en      = bus.zero;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign bus.memRead  = mem_read;
  assign bus.memWrite = mem_write;
  assign bus.iOrD     = i_or_d;
  assign bus.irWrite  = ir_write;
  assign bus.pcEn     = pc_en;
  assign bus.pcSrc    = pc_src;
  assign bus.aluSrcA  = alu_src_a;
  assign bus.aluSrcB  = alu_src_b;
  assign bus.aluOp    = alu_op;
  assign bus.regWrite = reg_write;
  assign bus.regDst   = reg_dst;
  assign bus.memToReg = mem_to_reg;
  assign bus.illegal  = illegal;

endmodule
